// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall controller for the 5-stage MIPS core.
// Detects load-use hazards against the instruction in IF/ID. Flushes IF/ID on a
// taken branch. Freezes the back half of the pipe while a multi-cycle data-memory
// access completes. Also keeps a saturating count of cycles in which the PC
// did not advance.
module hazard_ctrl #(
    parameter int MEM_LAT = 3,   // data-memory latency in cycles, 1..16 (1 = no wait state)
    parameter int CNT_W   = 16   // stall performance counter width
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rtaddr_i,
    input  logic [4:0]       ifid_rsaddr_i,
    input  logic [4:0]       ifid_rtaddr_i,
    input  logic             ifid_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memaccess_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // State encodings stay two bits wide to match existing debug tooling.
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;

    // With MEM_LAT=1 the memory answers in the access cycle, so the wait path is dead.
    localparam bit         HAS_WAIT  = (MEM_LAT >= 2);
    // The first wait cycle is spent in RUN. wcnt therefore counts only the
    // remaining held cycles after the move into MEM_WAIT.
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(MEM_LAT - 2) : 4'd0;

    logic [1:0]       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;   // load-use hazard on the instruction in IF/ID
    logic mh;   // memory hold: the back of the pipe must freeze this cycle

    // Load-use: a load in EX writes a register that the instruction in ID reads.
    // $zero is never a real dependency.
    always_comb begin
        lu = 1'b0;
        if (idex_memread_i && (idex_rtaddr_i != 5'd0)) begin
            if (idex_rtaddr_i == ifid_rsaddr_i)
                lu = 1'b1;
            else if (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i))
                lu = 1'b1;
        end
    end

    // Memory hold. In MEM_WAIT with wcnt==0 the data arrives: that is the
    // release cycle. exmem_memaccess_i is still the same lw/sw then, so it is ignored.
    always_comb begin
        mh = 1'b0;
        case (state_q)
            ST_RUN:      mh = exmem_memaccess_i && HAS_WAIT;
            ST_MEM_WAIT: mh = (wcnt_q != 4'd0);
            default:     mh = 1'b0;
        endcase
    end

    // Pipeline controls, fixed priority: memory hold > load-use > taken branch.
    // A branch that loses to a stall is re-resolved in ID once the stall clears.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (!rst_i) begin
            if (mh) begin
                pipe_hold_o  = 1'b1;
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
            end else if (lu) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
            end
        end
    end

    // Next-state logic for the memory-wait FSM and its countdown.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (exmem_memaccess_i && HAS_WAIT) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WAIT_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Unused encodings fall back to RUN.
                state_d = ST_RUN;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // Stall counter: counts every cycle the PC is frozen and sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers. A reset drops any wait that is in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Four instances share one stimulus bus:
// u0 MEM_LAT=3, u1 MEM_LAT=1, u2 MEM_LAT=5, u3 MEM_LAT=3 with a 2-bit counter.
// Each test checks the instance it targets.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       pcw, ifw, fl, bu, ho;
        logic [1:0] st;
    } ctl_t;

    typedef struct packed {
        logic        rst, mr;
        logic [4:0]  rtid, rs, rt;
        logic        ur, br, macc;
        ctl_t        exp;
        logic [15:0] cnt;
        logic        chk;
    } vec_t;

    localparam logic [1:0] RUN = 2'b00, MW = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, memread, uses_rt, br, macc;
    logic [4:0] rtid, rs, rt;

    logic [3:0]  pcw, ifw, fl, bu, ho;
    logic [1:0]  st [4];
    logic [15:0] cnt0, cnt1, cnt2;
    logic [1:0]  cnt3;

    int   nvec = 0;
    int   nerr = 0;
    vec_t sb_q[$];

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) u0 (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(memread), .idex_rtaddr_i(rtid),
        .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
        .branch_taken_i(br), .exmem_memaccess_i(macc),
        .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]), .ifid_flush_o(fl[0]),
        .idex_bubble_o(bu[0]), .pipe_hold_o(ho[0]), .state_o(st[0]), .stall_cnt_o(cnt0));

    hazard_ctrl #(.MEM_LAT(1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(memread), .idex_rtaddr_i(rtid),
        .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
        .branch_taken_i(br), .exmem_memaccess_i(macc),
        .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]), .ifid_flush_o(fl[1]),
        .idex_bubble_o(bu[1]), .pipe_hold_o(ho[1]), .state_o(st[1]), .stall_cnt_o(cnt1));

    hazard_ctrl #(.MEM_LAT(5), .CNT_W(16)) u2 (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(memread), .idex_rtaddr_i(rtid),
        .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
        .branch_taken_i(br), .exmem_memaccess_i(macc),
        .pc_write_o(pcw[2]), .ifid_write_o(ifw[2]), .ifid_flush_o(fl[2]),
        .idex_bubble_o(bu[2]), .pipe_hold_o(ho[2]), .state_o(st[2]), .stall_cnt_o(cnt2));

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(2)) u3 (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(memread), .idex_rtaddr_i(rtid),
        .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
        .branch_taken_i(br), .exmem_memaccess_i(macc),
        .pc_write_o(pcw[3]), .ifid_write_o(ifw[3]), .ifid_flush_o(fl[3]),
        .idex_bubble_o(bu[3]), .pipe_hold_o(ho[3]), .state_o(st[3]), .stall_cnt_o(cnt3));

    // Expected control sets
    function automatic ctl_t e_idle(logic [1:0] s);  return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, s}; endfunction
    function automatic ctl_t e_stall(logic [1:0] s); return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s}; endfunction
    function automatic ctl_t e_hold(logic [1:0] s);  return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s}; endfunction
    function automatic ctl_t e_flush(logic [1:0] s); return '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, s}; endfunction

    function automatic vec_t mk(logic r, logic m, logic [4:0] a, logic [4:0] s, logic [4:0] t,
                                logic u, logic b, logic c, ctl_t e, logic [15:0] n, logic k);
        vec_t v;
        v.rst = r; v.mr = m; v.rtid = a; v.rs = s; v.rt = t;
        v.ur = u; v.br = b; v.macc = c; v.exp = e; v.cnt = n; v.chk = k;
        return v;
    endfunction

    function automatic ctl_t obs(int sel);
        ctl_t r;
        r.pcw = pcw[sel]; r.ifw = ifw[sel]; r.fl = fl[sel];
        r.bu = bu[sel]; r.ho = ho[sel]; r.st = st[sel];
        return r;
    endfunction

    function automatic logic [15:0] cnt_obs(int sel);
        case (sel)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return {14'd0, cnt3};
        endcase
    endfunction

    // Drive one cycle of stimulus after the falling edge and queue its expectation.
    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_i = v.rst; memread = v.mr; rtid = v.rtid; rs = v.rs; rt = v.rt;
        uses_rt = v.ur; br = v.br; macc = v.macc;
        sb_q.push_back(v);
    endtask

    task automatic test_reset();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        // Reset with a hazard present: outputs must still show the idle set.
        q.push_back(mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(0);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL reset[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(0) !== e.cnt) begin nerr++; $display("FAIL reset[%0d] cnt got %0d want %0d", i, cnt_obs(0), e.cnt); end
            end
        end
    endtask

    task automatic test_load_use();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, e_stall(RUN), 16'd0, 1));
        q.push_back(mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, e_idle(RUN), 16'd1, 1));
        // $zero never stalls
        q.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, e_idle(RUN), 16'd1, 1));
        // rt-only match needs uses_rt
        q.push_back(mk(0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, e_idle(RUN), 16'd1, 1));
        q.push_back(mk(0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, e_stall(RUN), 16'd1, 1));
        // load but no address match
        q.push_back(mk(0, 1, 5'd9, 5'd3, 5'd4, 1, 0, 0, e_idle(RUN), 16'd2, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(0);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL load_use[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(0) !== e.cnt) begin nerr++; $display("FAIL load_use[%0d] cnt got %0d want %0d", i, cnt_obs(0), e.cnt); end
            end
        end
    endtask

    // MEM_LAT=3 access, followed back-to-back by a second access.
    task automatic test_back_to_back();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_hold(RUN), 16'd0, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_hold(MW),  16'd1, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_idle(MW),  16'd2, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_hold(RUN), 16'd2, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_hold(MW),  16'd3, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(MW),  16'd4, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd4, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(0);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL mem_wait[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(0) !== e.cnt) begin nerr++; $display("FAIL mem_wait[%0d] cnt got %0d want %0d", i, cnt_obs(0), e.cnt); end
            end
        end
    endtask

    task automatic test_mem_lat1();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        for (int k = 0; k < 3; k++)
            q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_idle(RUN), 16'd0, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(1);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL lat1[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(1) !== e.cnt) begin nerr++; $display("FAIL lat1[%0d] cnt got %0d want %0d", i, cnt_obs(1), e.cnt); end
            end
        end
    endtask

    task automatic test_branch_priority();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0, e_stall(RUN), 16'd0, 1));
        q.push_back(mk(0, 0, 5'd7, 5'd7, 5'd0, 0, 1, 0, e_flush(RUN), 16'd1, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN),  16'd1, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(0);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL branch[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(0) !== e.cnt) begin nerr++; $display("FAIL branch[%0d] cnt got %0d want %0d", i, cnt_obs(0), e.cnt); end
            end
        end
    endtask

    // MEM_LAT=5: four held cycles mask branch and load-use; the release cycle does not.
    task automatic test_hold_masks();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, e_hold(RUN),  16'd0, 1));
        q.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, e_hold(MW),   16'd1, 1));
        q.push_back(mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 1, 1, e_hold(MW),   16'd2, 1));
        q.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, e_hold(MW),   16'd3, 1));
        q.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, e_stall(MW),  16'd4, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN),  16'd5, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(2);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL hold_mask[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(2) !== e.cnt) begin nerr++; $display("FAIL hold_mask[%0d] cnt got %0d want %0d", i, cnt_obs(2), e.cnt); end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, e_hold(RUN),  16'd0, 1));
        q.push_back(mk(1, 1, 5'd6, 5'd6, 5'd0, 0, 1, 1, e_idle(MW),   16'd1, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN),  16'd0, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(0);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL rst_wait[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(0) !== e.cnt) begin nerr++; $display("FAIL rst_wait[%0d] cnt got %0d want %0d", i, cnt_obs(0), e.cnt); end
            end
        end
    endtask

    task automatic test_saturate();
        vec_t q[$];
        vec_t e;
        ctl_t o;
        q.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN), 16'd0, 0));
        q.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, e_stall(RUN), 16'd0, 1));
        q.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, e_stall(RUN), 16'd1, 1));
        q.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, e_stall(RUN), 16'd2, 1));
        q.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, e_stall(RUN), 16'd3, 1));
        q.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, e_stall(RUN), 16'd3, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN),  16'd3, 1));
        q.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, e_idle(RUN),  16'd3, 1));
        foreach (q[i]) begin
            drive(q[i]);
            #4;
            e = sb_q.pop_front();
            o = obs(3);
            nvec++;
            if (o !== e.exp) begin nerr++; $display("FAIL saturate[%0d] ctl got %b want %b", i, o, e.exp); end
            if (e.chk) begin
                nvec++;
                if (cnt_obs(3) !== e.cnt) begin nerr++; $display("FAIL saturate[%0d] cnt got %0d want %0d", i, cnt_obs(3), e.cnt); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; memread = 1'b0; rtid = 5'd0; rs = 5'd0; rt = 5'd0;
        uses_rt = 1'b0; br = 1'b0; macc = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_lat1();
        test_branch_priority();
        test_hold_masks();
        test_reset_mid_wait();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
